// File: rtl/regfile_bank.sv
// regfile_bank: 32 x 32-bit register storage with one write port and a flattened 1024-bit contents bus.
// Define REGFILE_SCOREBOARD_EN to add the busy_set/busy_addr/busy_vec pending-write scoreboard.
module regfile_bank #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [4:0]                 wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic                       busy_set,
    input  logic [4:0]                 busy_addr,
    output logic [NUM_REGS-1:0]        busy_vec,
`endif
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_ack,
    output logic [4:0]                 last_wr_addr
);
    logic commit;
    assign commit = wr_en && (wr_addr != 5'd0);
    assign regs_out[DATA_W-1:0] = '0;
    genvar i;
    for (i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] r;
        always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) r <= '0;
            else if (commit && wr_addr == 5'(i)) r <= wr_data;
        assign regs_out[i*DATA_W +: DATA_W] = r;
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_ack       <= 1'b0;
            last_wr_addr <= 5'd0;
        end else begin
            wr_ack <= commit;
            if (commit) last_wr_addr <= wr_addr;
        end
`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_setv, busy_clr;
    assign busy_setv = busy_set ? NUM_REGS'(1) << busy_addr : '0;
    assign busy_clr  = commit ? NUM_REGS'(1) << wr_addr : '0;
    // set is applied after clear so a new pending instruction wins on the same register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) busy_vec <= '0;
        else busy_vec <= ((busy_vec & ~busy_clr) | busy_setv) & ~NUM_REGS'(1);
`endif
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed table-driven bench for regfile_bank plus hand-written reset and scoreboard sequences.
module tb_regfile_bank;
    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [1023:0] regs_out;
    logic          wr_ack;
    logic [4:0]    last_wr_addr;
`ifdef REGFILE_SCOREBOARD_EN
    logic          busy_set;
    logic [4:0]    busy_addr;
    logic [31:0]   busy_vec;
`endif
    int checks = 0;
    int failures = 0;

    regfile_bank dut (
        .clock(clock),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
`ifdef REGFILE_SCOREBOARD_EN
        .busy_set(busy_set),
        .busy_addr(busy_addr),
        .busy_vec(busy_vec),
`endif
        .regs_out(regs_out),
        .wr_ack(wr_ack),
        .last_wr_addr(last_wr_addr)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (reset_n && wr_en) assert (!$isunknown(wr_addr)) else $error("wr_addr unknown while wr_en high");

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        int          idx;
        logic [31:0] val;
        logic        ack;
        logic [4:0]  last;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [1023:0] exp);
        checks++;
        for (int k = 0; k < 32; k++)
            if (regs_out[k*32 +: 32] !== exp[k*32 +: 32]) begin
                failures++;
                $display("FAIL %s: slice %0d got %h expected %h", name, k, regs_out[k*32 +: 32], exp[k*32 +: 32]);
                break;
            end
    endtask

    task automatic step(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [1023:0] exp_bus;

    initial begin
        tv[0] = '{1'b1, 5'd7,  32'h12345678, 7,  32'h12345678, 1'b1, 5'd7};
        tv[1] = '{1'b0, 5'd7,  32'hFFFFFFFF, 7,  32'h12345678, 1'b0, 5'd7};
        tv[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 0,  32'h00000000, 1'b0, 5'd7};
        tv[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 31, 32'hA5A5A5A5, 1'b1, 5'd31};
        tv[4] = '{1'b1, 5'd31, 32'h5A5A5A5A, 31, 32'h5A5A5A5A, 1'b1, 5'd31};
        tv[5] = '{1'b1, 5'd1,  32'h00000001, 1,  32'h00000001, 1'b1, 5'd1};
        tv[6] = '{1'b0, 5'd0,  32'h00000000, 31, 32'h5A5A5A5A, 1'b0, 5'd1};
        tv[7] = '{1'b1, 5'd3,  32'h00000042, 3,  32'h00000042, 1'b1, 5'd3};
`ifdef REGFILE_SCOREBOARD_EN
        busy_set  = 1'b0;
        busy_addr = 5'd0;
`endif
        reset_n = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_bus("reset_bus", '0);
        chk("reset_ack", 32'(wr_ack), 32'd0);
        chk("reset_last", 32'(last_wr_addr), 32'd0);
`ifdef REGFILE_SCOREBOARD_EN
        chk("reset_busy", busy_vec, 32'd0);
`endif
        reset_n = 1'b1;
        step(1'b0, 5'd5, 32'hDEADBEEF);
        chk_bus("post_release_bus", '0);

        for (int v = 0; v < 8; v++) begin
            step(tv[v].en, tv[v].addr, tv[v].data);
            chk($sformatf("vec%0d_data", v), regs_out[tv[v].idx*32 +: 32], tv[v].val);
            chk($sformatf("vec%0d_ack", v), 32'(wr_ack), 32'(tv[v].ack));
            chk($sformatf("vec%0d_last", v), 32'(last_wr_addr), 32'(tv[v].last));
        end

        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h0BADF00D;
        #1;
        chk("no_bypass_pre", regs_out[7*32 +: 32], 32'h12345678);
        @(posedge clock);
        @(negedge clock);
        chk("no_bypass_post", regs_out[7*32 +: 32], 32'h0BADF00D);

        exp_bus = '0;
        exp_bus[1*32 +: 32]  = 32'h00000001;
        exp_bus[3*32 +: 32]  = 32'h00000042;
        exp_bus[7*32 +: 32]  = 32'h0BADF00D;
        exp_bus[31*32 +: 32] = 32'h5A5A5A5A;
        chk_bus("full_bus", exp_bus);

        wr_en = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk_bus("async_reset_bus", '0);
        chk("async_reset_last", 32'(last_wr_addr), 32'd0);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        @(posedge clock);
        #1;
        chk("reset_discard_write", regs_out[5*32 +: 32], 32'd0);
        chk("reset_discard_ack", 32'(wr_ack), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 5'd0, 32'd0);
        chk_bus("after_reset_bus", '0);
        step(1'b1, 5'd5, 32'hCAFEF00D);
        chk("rewrite_data", regs_out[5*32 +: 32], 32'hCAFEF00D);
        chk("rewrite_ack", 32'(wr_ack), 32'd1);
        chk("rewrite_last", 32'(last_wr_addr), 32'd5);

`ifdef REGFILE_SCOREBOARD_EN
        busy_set  = 1'b1;
        busy_addr = 5'd9;
        step(1'b0, 5'd0, 32'd0);
        chk("busy_set9", busy_vec, 32'h00000200);
        step(1'b1, 5'd9, 32'h99);
        chk("busy_set_wins", busy_vec, 32'h00000200);
        busy_set = 1'b0;
        step(1'b1, 5'd9, 32'h98);
        chk("busy_clear9", busy_vec, 32'h00000000);
        busy_set  = 1'b1;
        busy_addr = 5'd0;
        step(1'b0, 5'd0, 32'd0);
        chk("busy_r0", busy_vec, 32'h00000000);
        busy_addr = 5'd2;
        step(1'b0, 5'd0, 32'd0);
        busy_addr = 5'd4;
        step(1'b1, 5'd2, 32'h22);
        chk("busy_both", busy_vec, 32'h00000010);
        busy_set = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Storage half of the processor register file: 32 x 32-bit architectural registers with one synchronous write port.
- All register contents are exposed continuously on a flattened 1024-bit bus.
- The bus feeds the two 32:1 read-port selectors (rs/rt) directly downstream; read selection is done there, not here.
- Register 0 is hardwired to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers; fixed at 32 to match the 5-bit address and 1024-bit bus.
- DATA_W, 32, register width in bits.

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request, sampled on rising clock
- wr_addr  input  5  destination register index
- wr_data  input  32  write data
- regs_out  output  1024  flattened register contents; register i occupies bits [32*i+31 : 32*i]
- wr_ack  output  1  registered; high for one cycle after a committed write to a nonzero register
- last_wr_addr  output  5  registered; index of the most recent committed write
- busy_set  input  1  (SCOREBOARD_EN only) mark register busy_addr as pending
- busy_addr  input  5  (SCOREBOARD_EN only) register index to mark pending
- busy_vec  output  32  (SCOREBOARD_EN only) pending-write bit per register

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous release on clock edge):
  - all 32 registers = 0; regs_out = 0
  - wr_ack = 0; last_wr_addr = 0; busy_vec = 0
  - reset mid-write discards the write
- Write commit:
  - on a rising clock with wr_en = 1 and wr_addr != 0, register[wr_addr] <= wr_data
  - visible on regs_out the same edge (one-cycle latency from wr_en sample to bus update)
  - wr_ack = 1 and last_wr_addr = wr_addr in the following cycle
- Writes to register 0:
  - no storage change; regs_out[31:0] is always 0
  - wr_ack stays 0; last_wr_addr unchanged
- wr_en = 0: no state change; wr_ack = 0 next cycle.
- No read-during-write bypass:
  - regs_out reflects pre-write contents until the commit edge
  - the downstream selector sees new data one cycle after wr_en is sampled; pipeline forwarding is handled elsewhere
- Back-to-back writes, one per cycle, are fully supported, including repeated writes to the same register (last write wins).
- regs_out is driven purely from flops; there are no tristate or combinational paths from the write inputs.
- Write decode is a 5-to-32 one-hot enable; at most one register changes per edge.
- X on wr_addr while wr_en = 1 is illegal; verification flags it with an assertion.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN
- With macro defined:
  - busy_set / busy_addr / busy_vec exist
  - busy_set = 1 with busy_addr != 0 sets busy_vec[busy_addr] on the edge
  - a committed write clears busy_vec[wr_addr]
  - same edge, same register, set and clear: set wins (new instruction pending)
  - same edge, different registers: both take effect
  - busy_vec[0] is always 0
- Without macro: those ports and flops are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n = 0, drive wr_en = 1, wr_addr = 5, wr_data = 32'hDEADBEEF -> regs_out all zero, wr_ack = 0; release reset -> still zero until the next enabled edge.
- Basic write: wr_en = 1, wr_addr = 7, wr_data = 32'h12345678 for one cycle -> regs_out[255:224] = 32'h12345678 after the edge; next cycle wr_ack = 1, last_wr_addr = 7; all other slices 0.
- Register 0: wr_en = 1, wr_addr = 0, wr_data = 32'hFFFFFFFF -> regs_out[31:0] stays 0, wr_ack = 0, last_wr_addr unchanged.
- Back-to-back: write r31 = 32'hA5A5A5A5 then r31 = 32'h5A5A5A5A on consecutive cycles, then r1 = 32'h1 -> regs_out[1023:992] = 32'h5A5A5A5A, regs_out[63:32] = 1, wr_ack high three consecutive cycles.
- Async reset mid-operation: after loading r3 = 32'h00000042, pulse reset_n low between clock edges -> regs_out = 0 immediately, without waiting for a clock edge.
- Scoreboard (REGFILE_SCOREBOARD_EN):
  - busy_set with busy_addr = 9 -> busy_vec = 32'h00000200
  - then write r9 together with busy_set on r9 in the same cycle -> busy_vec stays 32'h00000200
  - then write r9 alone -> busy_vec = 0
